// File: rtl/debug_unit_ctrl_pkg.sv
// Shared types and defaults for the debug unit: FSM encoding, command bytes, dump size and watchdog limit.
// The watchdog limit only matters in builds with DBG_TIMEOUT_EN defined.
package debug_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      STEP      = 3'd2,
      SEND_LOAD = 3'd3,
      SEND_WAIT = 3'd4,
      DONE      = 3'd5
   } state_e;

   localparam logic [7:0] CMD_CONT_DEF   = 8'h63;
   localparam logic [7:0] CMD_STEP_DEF   = 8'h73;
   localparam int         SNAP_BYTES_DEF = 32;
   localparam int         TX_TIMEOUT_DEF = 8192;
   localparam int         WDOG_W         = 13;

endpackage

// File: rtl/debug_unit_ctrl_if.sv
// Signal bundle between the debug unit and its UART / datapath neighbours.
// The tx_err flag exists only when DBG_TIMEOUT_EN is defined.
interface debug_unit_ctrl_if;
   import debug_pkg::*;

   // UART handshake: rx_done qualifies rx_data for one cycle; tx_start is a one-cycle
   // request holding tx_data, and the byte belongs to the transmitter until tx_done pulses.
   logic [7:0] rx_data;
   logic       rx_done;
   logic       tx_done;
   logic       halt;
   logic [7:0] snap_data;
   logic       dp_enable;
   logic [7:0] snap_addr;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       led_idle;
   logic       led_halted;
   logic       sent_flag;
   logic [7:0] send_count;
   state_e     dbg_state;
`ifdef DBG_TIMEOUT_EN
   logic       tx_err;
`endif

   modport master (
      input  rx_data, rx_done, tx_done, halt, snap_data,
      output dp_enable, snap_addr, tx_data, tx_start, led_idle, led_halted,
             sent_flag, send_count, dbg_state
`ifdef DBG_TIMEOUT_EN
      , output tx_err
`endif
   );

   modport slave (
      output rx_data, rx_done, tx_done, halt, snap_data,
      input  dp_enable, snap_addr, tx_data, tx_start, led_idle, led_halted,
             sent_flag, send_count, dbg_state
`ifdef DBG_TIMEOUT_EN
      , input tx_err
`endif
   );

endinterface

// File: rtl/debug_unit_ctrl_dump_sequencer.sv
// Byte pump for the snapshot dump: address counter, transmit handshake, byte counter.
// With DBG_TIMEOUT_EN a per-byte watchdog forces progress and raises a sticky tx_err.
module dump_sequencer
   import debug_pkg::*;
#(
   parameter int SNAP_BYTES = SNAP_BYTES_DEF
`ifdef DBG_TIMEOUT_EN
   , parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic       wait_i,
   input  logic [7:0] snap_data_i,
   input  logic       tx_done_i,
   output logic [7:0] snap_addr_o,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   output logic [7:0] send_count_o,
   output logic       byte_done_o,
   output logic       last_o
`ifdef DBG_TIMEOUT_EN
   , output logic     tx_err_o
`endif
);

   logic [7:0] addr_q, addr_d;
   logic [7:0] txd_q, txd_d;
   logic [7:0] cnt_q, cnt_d;
   logic       start_q, start_d;
   logic       timeout;

`ifdef DBG_TIMEOUT_EN
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TX_TIMEOUT - 1);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              err_q, err_d;

   assign timeout  = (wdog_q == WDOG_LAST);
   assign tx_err_o = err_q;

   always_comb begin
      wdog_d = wdog_q;
      err_d  = err_q;
      if (load_i)
         wdog_d = '0;
      else if (wait_i)
         wdog_d = wdog_q + 1'b1;
      // A real tx_done in the same cycle wins over the watchdog.
      if (wait_i && timeout && !tx_done_i)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign byte_done_o  = wait_i && (tx_done_i || timeout);
   assign last_o       = (addr_q == 8'(SNAP_BYTES - 1));
   assign snap_addr_o  = addr_q;
   assign tx_data_o    = txd_q;
   assign tx_start_o   = start_q;
   assign send_count_o = cnt_q;

   always_comb begin
      addr_d  = addr_q;
      txd_d   = txd_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      if (load_i) begin
         txd_d   = snap_data_i;
         start_d = 1'b1;
      end
      if (wait_i && tx_done_i)
         cnt_d = cnt_q + 8'd1;
      if (byte_done_o && !last_o)
         addr_d = addr_q + 8'd1;
      // Outside the dump the window pointer parks at byte 0.
      if (!load_i && !wait_i)
         addr_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         txd_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         txd_q   <= txd_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Run/step/dump controller: decodes UART commands, gates the datapath, triggers snapshot dumps.
// Defining DBG_TIMEOUT_EN adds the per-byte transmit watchdog and the tx_err flag.
module debug_unit_ctrl
   import debug_pkg::*;
#(
   parameter int         SNAP_BYTES = SNAP_BYTES_DEF,
   parameter logic [7:0] CMD_CONT   = CMD_CONT_DEF,
   parameter logic [7:0] CMD_STEP   = CMD_STEP_DEF
`ifdef DBG_TIMEOUT_EN
   , parameter int       TX_TIMEOUT = TX_TIMEOUT_DEF
`endif
) (
   input logic                clk,
   input logic                reset,
   debug_unit_ctrl_if.master  bus
);

   state_e state_q, state_d;
   logic   dp_enable_q, dp_enable_d;
   logic   led_idle_q, led_idle_d;
   logic   led_halted_q, led_halted_d;
   logic   sent_flag_q, sent_flag_d;
   logic   byte_done;
   logic   last_byte;

   always_comb begin
      state_d      = state_q;
      led_halted_d = led_halted_q;
      case (state_q)
         IDLE: begin
            if (bus.rx_done && !led_halted_q) begin
               if (bus.rx_data == CMD_CONT)
                  state_d = RUN;
               else if (bus.rx_data == CMD_STEP)
                  state_d = STEP;
            end
         end
         RUN: begin
            if (bus.halt) begin
               led_halted_d = 1'b1;
               state_d      = SEND_LOAD;
            end
         end
         STEP: begin
            if (bus.halt)
               led_halted_d = 1'b1;
            state_d = SEND_LOAD;
         end
         SEND_LOAD: state_d = SEND_WAIT;
         SEND_WAIT: begin
            if (byte_done)
               state_d = last_byte ? DONE : SEND_LOAD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are registered from the next state so they line up with state_q.
      dp_enable_d = (state_d == RUN) || (state_d == STEP);
      led_idle_d  = (state_d == IDLE);
      sent_flag_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         dp_enable_q  <= 1'b0;
         led_idle_q   <= 1'b1;
         led_halted_q <= 1'b0;
         sent_flag_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dp_enable_q  <= dp_enable_d;
         led_idle_q   <= led_idle_d;
         led_halted_q <= led_halted_d;
         sent_flag_q  <= sent_flag_d;
      end
   end

   dump_sequencer #(
      .SNAP_BYTES (SNAP_BYTES)
`ifdef DBG_TIMEOUT_EN
      , .TX_TIMEOUT (TX_TIMEOUT)
`endif
   ) u_seq (
      .clk          (clk),
      .reset        (reset),
      .load_i       (state_q == SEND_LOAD),
      .wait_i       (state_q == SEND_WAIT),
      .snap_data_i  (bus.snap_data),
      .tx_done_i    (bus.tx_done),
      .snap_addr_o  (bus.snap_addr),
      .tx_data_o    (bus.tx_data),
      .tx_start_o   (bus.tx_start),
      .send_count_o (bus.send_count),
      .byte_done_o  (byte_done),
      .last_o       (last_byte)
`ifdef DBG_TIMEOUT_EN
      , .tx_err_o   (bus.tx_err)
`endif
   );

   assign bus.dp_enable  = dp_enable_q;
   assign bus.led_idle   = led_idle_q;
   assign bus.led_halted = led_halted_q;
   assign bus.sent_flag  = sent_flag_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: doc/debug_unit_ctrl.md
Name: debug_unit_ctrl

Overview:
- Run/step/dump controller for the pipelined datapath.
- Takes command bytes from the UART receiver and gates the datapath with a clock enable.
- After each step, or on halt, walks a snapshot byte window and pushes every byte to the UART transmitter.
- Sits between uart_rx/uart_tx and the datapath core, in the 12.5 MHz clk domain.

Parameters:
- SNAP_BYTES, 32: number of snapshot bytes dumped per stop (1..256).
- CMD_CONT, 8'h63: 'c', run continuously until halt.
- CMD_STEP, 8'h73: 's', advance exactly one datapath cycle.
- TX_TIMEOUT, 8192: watchdog cycles per byte. One 19200-baud frame is about 6510 clk. Used only with DBG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 12.5 MHz
- reset  in  1  asynchronous, active-high
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle pulse per received byte
- tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
- halt  in  1  datapath halt instruction retired, level
- snap_data  in  8  combinational snapshot byte selected by snap_addr
- dp_enable  out  1  datapath clock enable
- snap_addr  out  8  snapshot byte index
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- led_idle  out  1  high in IDLE
- led_halted  out  1  sticky halt indicator
- sent_flag  out  1  one-cycle pulse when a dump completes
- send_count  out  8  total bytes sent since reset, wraps 255->0

Behaviour:
- Reset values (asynchronous): state=IDLE, dp_enable=0, snap_addr=0, tx_data=0, tx_start=0, led_idle=1, led_halted=0, sent_flag=0, send_count=0.
- Reset mid-operation aborts the run or dump immediately; there is no partial-byte recovery.
- All outputs are registered.
- IDLE:
  - led_idle=1.
  - rx_done with rx_data==CMD_CONT -> RUN; with CMD_STEP -> STEP.
  - Other bytes are ignored.
  - Both commands are ignored while led_halted=1; only reset clears it.
- RUN:
  - dp_enable=1 every cycle.
  - halt sampled 1 -> dp_enable=0 next cycle, led_halted<=1, snap_addr<=0, go SEND_LOAD.
  - rx bytes in RUN are dropped. halt and rx_done in the same cycle: halt wins.
- STEP:
  - dp_enable=1 for exactly one cycle, then SEND_LOAD with snap_addr=0.
  - If halt=1 in that cycle, led_halted<=1.
- SEND_LOAD:
  - tx_data<=snap_data, tx_start=1 for one cycle, then SEND_WAIT.
  - Latency from entering SEND_LOAD to tx_start is 1 cycle.
- SEND_WAIT:
  - On tx_done: send_count<=send_count+1.
  - If snap_addr==SNAP_BYTES-1 -> DONE; else snap_addr<=snap_addr+1 and go SEND_LOAD.
- DONE: sent_flag=1 for one cycle, snap_addr<=0, -> IDLE.
- Ignored pulses:
  - tx_done outside SEND_WAIT is ignored.
  - rx_done outside IDLE is ignored; no buffering.
- dp_enable is 0 in every state except RUN and STEP.

Optional Feature:
- Macro: DBG_TIMEOUT_EN.
- With it defined:
  - A 13-bit watchdog counts in SEND_WAIT and clears on every entry to SEND_LOAD.
  - Reaching TX_TIMEOUT treats the byte as sent: advance as if tx_done, but do not increment send_count.
  - Adds output tx_err, sticky, cleared by reset.
- Without it: SEND_WAIT waits on tx_done indefinitely, and tx_err does not exist.

Decomposition:
- Package debug_pkg holds:
  - state encoding: IDLE, RUN, STEP, SEND_LOAD, SEND_WAIT, DONE;
  - default command constants;
  - the TX_TIMEOUT default.
- One sub-module, dump_sequencer, owns:
  - SEND_LOAD/SEND_WAIT handshake;
  - snap_addr counter;
  - send_count and the optional watchdog.
- Start/done handshake with the top FSM.

Test Plan:
- Idle command filter: reset, send byte 8'h41 -> no state change, dp_enable stays 0, led_idle=1.
- Single step:
  - Stimulus: send 's'.
  - dp_enable high exactly 1 cycle.
  - 32 tx_start pulses with snap_addr 0..31, each answered by tx_done.
  - send_count=32, one sent_flag pulse, back to IDLE.
- Continuous run to halt:
  - Stimulus: send 'c', raise halt after 100 cycles.
  - dp_enable high 100 cycles, then 0.
  - led_halted=1, dump of 32 bytes.
  - A later 'c' or 's' is ignored.
- Simultaneous events: in RUN, assert halt and rx_done('s') in the same cycle -> halt taken, no extra step, dump starts.
- Reset mid-dump: assert reset after 10 tx_done -> all outputs at reset values immediately, send_count=0, led_halted=0.
- DBG_TIMEOUT_EN: withhold tx_done for 8192 cycles on byte 5 -> sequencer advances to snap_addr=6, tx_err=1, send_count ends at 31.
